// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared controller encodings: FSM states, op_codes, mux selects.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        LUI    = 4'd12,
        AUIPC  = 4'd13,
        TRAP   = 4'd14
    } state_e;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [2:0] c_imm_i     = 3'b000;
    localparam logic [2:0] c_imm_s     = 3'b001;
    localparam logic [2:0] c_imm_b     = 3'b010;
    localparam logic [2:0] c_imm_j     = 3'b011;
    localparam logic [2:0] c_imm_u     = 3'b100;
    localparam logic [2:0] c_imm_shamt = 3'b101;

    localparam logic [1:0] c_alu_add    = 2'b00;
    localparam logic [1:0] c_alu_branch = 2'b01;
    localparam logic [1:0] c_alu_funct  = 2'b10;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_mem    = 2'b01;
    localparam logic [1:0] c_res_pc4    = 2'b10;
    localparam logic [1:0] c_res_imm    = 2'b11;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    // States that wait on mem_ready and are guarded by the wait timer
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Brief    : Memory request/ready handshake between controller and memory.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
//  Module   : mc_wait_timer
//  Brief    : Counts stalled memory cycles; flags the cycle that hits the limit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_tick,
    output logic      o_expire
);

    logic [7:0] r_count_q;
    logic [7:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = 8'd0;
        end else if (i_tick) begin
            w_count_d = r_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= 8'd0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    // A stalled cycle that would bring the count to WAIT_MAX is the timeout
    assign o_expire = i_tick && (r_count_q == 8'(WAIT_MAX - 1));

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multicycle RISC-V control FSM with memory wait timeout and trap.
//             Define MC_PERF_CNT_EN to add the instret retired-instr counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  wire logic         clk,
    input  wire logic         reset,
    multicycle_ctrl_if.master mem_bus,
    input  wire logic [6:0]   op_code,
    input  wire logic [2:0]   funct3,
    input  wire logic         take,
    output logic              adr_src,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [1:0]        result_src,
    output logic [2:0]        imm_src,
    output logic              trap
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       instret
`endif
);

    state_e r_state_q, w_state_d;
    state_e w_out_state;
    logic   r_trap_q, w_trap_d;
    logic   w_in_mem, w_clear, w_timeout, w_ready;

    assign w_in_mem = is_mem_state(r_state_q);
    assign w_clear  = !w_in_mem || (w_state_d != r_state_q);

    mc_wait_timer #(.WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_clear),
        .i_tick   (w_in_mem && !mem_bus.mem_ready),
        .o_expire (w_timeout)
    );

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            FETCH:  if (mem_bus.mem_ready) w_state_d = DECODE;
                    else if (w_timeout)    w_state_d = TRAP;
            DECODE: begin
                case (op_code)
                    c_op_load, c_op_store: w_state_d = MEMADR;
                    c_op_r:                w_state_d = EXEC_R;
                    c_op_i:                w_state_d = EXEC_I;
                    c_op_branch:           w_state_d = BRANCH;
                    c_op_jal:              w_state_d = JAL;
                    c_op_jalr:             w_state_d = JALR;
                    c_op_lui:              w_state_d = LUI;
                    c_op_auipc:            w_state_d = AUIPC;
                    default:               w_state_d = TRAP;
                endcase
            end
            MEMADR: w_state_d = (op_code == c_op_store) ? MEMWR : MEMRD;
            MEMRD:  if (mem_bus.mem_ready) w_state_d = MEMWB;
                    else if (w_timeout)    w_state_d = TRAP;
            MEMWR:  if (mem_bus.mem_ready) w_state_d = FETCH;
                    else if (w_timeout)    w_state_d = TRAP;
            EXEC_R, EXEC_I: w_state_d = ALUWB;
            MEMWB, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC: w_state_d = FETCH;
            TRAP:    w_state_d = TRAP;
            default: w_state_d = TRAP;
        endcase
    end

    assign w_trap_d = r_trap_q || (w_state_d == TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= FETCH;
            r_trap_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_trap_q  <= w_trap_d;
        end
    end

    // Reset presents FETCH decode but with no request and no fetch strobes
    assign w_out_state = reset ? FETCH : r_state_q;
    assign w_ready     = mem_bus.mem_ready && !reset;
    assign trap        = r_trap_q && !reset;

    always_comb begin
        mem_bus.mem_req = 1'b0;
        mem_bus.mem_we  = 1'b0;
        adr_src         = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = c_srca_pc;
        alu_src_b       = c_srcb_rs2;
        alu_op          = c_alu_add;
        result_src      = c_res_aluout;
        imm_src         = c_imm_i;
        case (w_out_state)
            FETCH: begin
                mem_bus.mem_req = !reset;
                alu_src_b       = c_srcb_four;
                ir_write        = w_ready;
                pc_write        = w_ready;
            end
            DECODE: begin
                alu_src_a = c_srca_oldpc;
                alu_src_b = c_srcb_imm;
                imm_src   = c_imm_b;
            end
            MEMADR: begin
                alu_src_a = c_srca_rs1;
                alu_src_b = c_srcb_imm;
                imm_src   = (op_code == c_op_store) ? c_imm_s : c_imm_i;
            end
            MEMRD: begin
                mem_bus.mem_req = 1'b1;
                adr_src         = 1'b1;
            end
            MEMWR: begin
                mem_bus.mem_req = 1'b1;
                mem_bus.mem_we  = 1'b1;
                adr_src         = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = c_res_mem;
            end
            EXEC_R: begin
                alu_src_a = c_srca_rs1;
                alu_op    = c_alu_funct;
            end
            EXEC_I: begin
                alu_src_a = c_srca_rs1;
                alu_src_b = c_srcb_imm;
                alu_op    = c_alu_funct;
                imm_src   = (funct3 == 3'b001 || funct3 == 3'b101) ? c_imm_shamt : c_imm_i;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = c_srca_rs1;
                alu_op    = c_alu_branch;
                pc_write  = take;
            end
            JAL, JALR: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                result_src = c_res_pc4;
                alu_src_a  = (w_out_state == JAL) ? c_srca_oldpc : c_srca_rs1;
                alu_src_b  = c_srcb_imm;
                imm_src    = (w_out_state == JAL) ? c_imm_j : c_imm_i;
            end
            LUI: begin
                reg_write  = 1'b1;
                result_src = c_res_imm;
                imm_src    = c_imm_u;
            end
            AUIPC: begin
                reg_write = 1'b1;
                alu_src_a = c_srca_oldpc;
                alu_src_b = c_srcb_imm;
                imm_src   = c_imm_u;
            end
            default: ;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_instret_q, w_instret_d;

    always_comb begin
        w_instret_d = r_instret_q;
        if ((w_state_d == FETCH) && (r_state_q != FETCH)) begin
            w_instret_d = r_instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret_q <= 32'd0;
        end else begin
            r_instret_q <= w_instret_d;
        end
    end

    assign instret = r_instret_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Brief    : Directed self-checking bench for multicycle_ctrl (MEM_WAIT_MAX=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic        take;
    logic        adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0]  imm_src;
`ifdef MC_PERF_CNT_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_ctrl_if mem_bus ();

    multicycle_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_bus    (mem_bus),
        .op_code    (op_code),
        .funct3     (funct3),
        .take       (take),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .trap       (trap)
`ifdef MC_PERF_CNT_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input string tag);
        chk({tag, "_req"},  {31'd0, mem_bus.mem_req}, 32'd1);
        chk({tag, "_adr"},  {31'd0, adr_src},         32'd0);
        chk({tag, "_srcb"}, {30'd0, alu_src_b},       32'd2);
    endtask

    // Completes a zero-wait fetch; returns one tick into DECODE
    task automatic do_fetch(input string tag);
        mem_bus.mem_ready = 1'b1;
        #1;
        expect_fetch(tag);
        chk({tag, "_irw"}, {31'd0, ir_write}, 32'd1);
        step();
        mem_bus.mem_ready = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; op_code = 7'd0; funct3 = 3'd0; take = 1'b0;
        mem_bus.mem_ready = 1'b0;
        step(); step();
        chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_srcb",    {30'd0, alu_src_b},       32'd2);
        chk("rst_trap",    {31'd0, trap},            32'd0);
        mem_bus.mem_ready = 1'b1; #1;
        chk("rst_irw",     {31'd0, ir_write},        32'd0);
        mem_bus.mem_ready = 1'b0;
`ifdef MC_PERF_CNT_EN
        chk("rst_instret", instret, 32'd0);
`endif
        reset = 1'b0;

        // lw with two fetch wait cycles, zero-wait read
        op_code = 7'b0000011; funct3 = 3'b010; #1;
        expect_fetch("lw_f1");
        chk("lw_f1_irw", {31'd0, ir_write}, 32'd0);
        step(); expect_fetch("lw_f2");
        step(); mem_bus.mem_ready = 1'b1; #1;
        expect_fetch("lw_f3");
        chk("lw_f3_irw", {31'd0, ir_write}, 32'd1);
        chk("lw_f3_pcw", {31'd0, pc_write}, 32'd1);
        step();
        chk("lw_dec_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("lw_dec_imm", {29'd0, imm_src},         32'd2);
        chk("lw_dec_irw", {31'd0, ir_write},        32'd0);
        chk("lw_dec_rw",  {31'd0, reg_write},       32'd0);
        step();
        chk("lw_adr_imm",  {29'd0, imm_src},   32'd0);
        chk("lw_adr_srca", {30'd0, alu_src_a}, 32'd2);
        chk("lw_adr_rw",   {31'd0, reg_write}, 32'd0);
        step();
        chk("lw_rd_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("lw_rd_adr", {31'd0, adr_src},         32'd1);
        chk("lw_rd_we",  {31'd0, mem_bus.mem_we},  32'd0);
        chk("lw_rd_rw",  {31'd0, reg_write},       32'd0);
        step(); mem_bus.mem_ready = 1'b0; #1;
        chk("lw_wb_rw",  {31'd0, reg_write},  32'd1);
        chk("lw_wb_res", {30'd0, result_src}, 32'd1);
        step();
        expect_fetch("lw_done");
        chk("lw_done_rw", {31'd0, reg_write}, 32'd0);

        // beq not taken, then taken: 3 cycles each
        op_code = 7'b1100011; take = 1'b0;
        do_fetch("beq0"); step();
        chk("beq0_pcw", {31'd0, pc_write}, 32'd0);
        chk("beq0_op",  {30'd0, alu_op},   32'd1);
        step(); expect_fetch("beq0_done");
        take = 1'b1;
        do_fetch("beq1"); step();
        chk("beq1_pcw", {31'd0, pc_write}, 32'd1);
        step(); expect_fetch("beq1_done");
        take = 1'b0;

        // slli / addi / add
        op_code = 7'b0010011; funct3 = 3'b001;
        do_fetch("slli"); step();
        chk("slli_imm",  {29'd0, imm_src},   32'd5);
        chk("slli_op",   {30'd0, alu_op},    32'd2);
        chk("slli_srcb", {30'd0, alu_src_b}, 32'd1);
        step();
        chk("slli_wb_rw",  {31'd0, reg_write},  32'd1);
        chk("slli_wb_res", {30'd0, result_src}, 32'd0);
        step(); funct3 = 3'b000;
        do_fetch("addi"); step();
        chk("addi_imm", {29'd0, imm_src}, 32'd0);
        step(); step();
        op_code = 7'b0110011;
        do_fetch("add"); step();
        chk("add_op",   {30'd0, alu_op},    32'd2);
        chk("add_srcb", {30'd0, alu_src_b}, 32'd0);
        step(); chk("add_wb_rw", {31'd0, reg_write}, 32'd1);
        step();

        // jal and lui
        op_code = 7'b1101111;
        do_fetch("jal"); step();
        chk("jal_rw",  {31'd0, reg_write},  32'd1);
        chk("jal_pcw", {31'd0, pc_write},   32'd1);
        chk("jal_res", {30'd0, result_src}, 32'd2);
        chk("jal_imm", {29'd0, imm_src},    32'd3);
        step(); expect_fetch("jal_done");
        op_code = 7'b0110111;
        do_fetch("lui"); step();
        chk("lui_res", {30'd0, result_src}, 32'd3);
        chk("lui_imm", {29'd0, imm_src},    32'd4);
        chk("lui_rw",  {31'd0, reg_write},  32'd1);
        step();

        // sw with memory never ready: TRAP after 4 wait cycles
        op_code = 7'b0100011;
        do_fetch("sw_to"); step();
        chk("sw_adr_imm", {29'd0, imm_src}, 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("sw_to_we", {31'd0, mem_bus.mem_we}, 32'd1);
            step();
        end
        chk("sw_to_trap", {31'd0, trap},            32'd1);
        chk("sw_to_req",  {31'd0, mem_bus.mem_req}, 32'd0);
        reset = 1'b1; step(); reset = 1'b0; #1;
        expect_fetch("sw_to_rst");
        chk("sw_to_rst_trap", {31'd0, trap}, 32'd0);

        // sw with ready on the 4th wait cycle completes
        do_fetch("sw_ok"); step(); step();
        for (int i = 0; i < 3; i++) step();
        mem_bus.mem_ready = 1'b1; #1;
        chk("sw_ok_we", {31'd0, mem_bus.mem_we}, 32'd1);
        step(); mem_bus.mem_ready = 1'b0; #1;
        expect_fetch("sw_ok_done");
        chk("sw_ok_trap", {31'd0, trap}, 32'd0);

        // illegal op_code: sticky trap, strobes low, cleared by reset
        op_code = 7'b1111111;
        do_fetch("ill"); step();
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ready = 1'(i % 2); #1;
            chk("ill_trap", {31'd0, trap}, 32'd1);
            chk("ill_strobes", {27'd0, mem_bus.mem_req, mem_bus.mem_we, ir_write, pc_write, reg_write}, 32'd0);
            step();
        end
        mem_bus.mem_ready = 1'b0;
        reset = 1'b1; #1;
        chk("ill_rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        step(); reset = 1'b0; #1;
        expect_fetch("ill_rst");
        chk("ill_rst_trap", {31'd0, trap}, 32'd0);

        // reset during MEMRD: restart at FETCH, late ready yields no write
        op_code = 7'b0000011;
        do_fetch("rrd"); step(); step();
        chk("rrd_rd_adr", {31'd0, adr_src}, 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        mem_bus.mem_ready = 1'b1; #1;
        expect_fetch("rrd_fetch");
        chk("rrd_rw0", {31'd0, reg_write}, 32'd0);
        step(); mem_bus.mem_ready = 1'b0; #1;
        chk("rrd_rw1", {31'd0, reg_write}, 32'd0);
        step();
        chk("rrd_rw2", {31'd0, reg_write}, 32'd0);
        reset = 1'b1; step(); reset = 1'b0;

`ifdef MC_PERF_CNT_EN
        chk("perf_zero", instret, 32'd0);
        op_code = 7'b0010011; funct3 = 3'b000;
        for (int i = 0; i < 10; i++) begin
            do_fetch("perf"); step(); step(); step();
        end
        chk("perf_ten", instret, 32'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: the maximum number of cycles a memory access may wait for mem_ready (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op_code, input, 7 bits: instruction register bits [6:0].
REQ-005 SHALL have port funct3, input, 3 bits: instruction register bits [14:12].
REQ-006 SHALL have port take, input, 1 bit: branch condition from the ALU/compare unit, valid in the BRANCH state.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory has completed the current access.
REQ-008 SHALL have ports mem_req and mem_we, outputs, 1 bit each: access request, and write qualifier for that request.
REQ-009 SHALL have ports adr_src, ir_write, pc_write and reg_write, outputs, 1 bit each: address mux select (0 = PC, 1 = ALU result register), IR load, PC load and register file write.
REQ-010 SHALL have ports alu_src_a, alu_src_b, alu_op and result_src, outputs, 2 bits each.
REQ-011 SHALL have port imm_src, output, 3 bits; encoding I=000, S=001, B=010, J=011, U=100, shamt=101.
REQ-012 SHALL have port trap, output, 1 bit: sticky flag for an illegal op_code or a memory timeout.
REQ-013 SHALL have port instret, output, 32 bits; it is present only under MC_PERF_CNT_EN.

Function
REQ-014 SHALL implement a Moore FSM. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
REQ-015 FETCH SHALL assert mem_req with adr_src=0, alu_src_a=00 (PC), alu_src_b=10 (const 4), alu_op=00, and hold until mem_ready.
REQ-016 In the FETCH cycle where mem_ready=1, the block SHALL pulse ir_write and pc_write for exactly that cycle, then move to DECODE.
REQ-017 DECODE SHALL take one cycle and compute the target (alu_src_a=01 old PC, alu_src_b=01 imm, imm_src=B). It SHALL branch on op_code: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC; any other value -> TRAP.
REQ-018 MEMADR SHALL add rs1+imm (imm_src=I for a load, S for a store), then go to MEMRD for a load or MEMWR for a store.
REQ-019 MEMRD and MEMWR SHALL assert mem_req with adr_src=1 (mem_we=1 in MEMWR only) and hold until mem_ready. MEMRD then goes to MEMWB; MEMWR then goes to FETCH.
REQ-020 MEMWB SHALL assert reg_write with result_src=01 for one cycle, then go to FETCH.
REQ-021 EXEC_R and EXEC_I SHALL set alu_op=10. EXEC_I SHALL set alu_src_b=01, with imm_src=shamt when funct3 is 001 or 101, else I. Both then go to ALUWB.
REQ-022 ALUWB SHALL assert reg_write with result_src=00, then go to FETCH.
REQ-023 BRANCH SHALL set alu_op=01 and assert pc_write only when take=1, then go to FETCH; it takes one cycle whether or not the branch is taken.
REQ-024 JAL and JALR SHALL assert reg_write with result_src=10 (PC+4) and pc_write, then go to FETCH. JAL uses imm_src=J with the old-PC base; JALR uses imm_src=I with the rs1 base.
REQ-025 LUI SHALL write the U immediate (result_src=11); AUIPC SHALL write old PC + U immediate. Each takes one cycle, then goes to FETCH.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-027 A wait counter SHALL clear on entry to each memory state and count each cycle with mem_ready=0. When it reaches MEM_WAIT_MAX, the next state SHALL be TRAP.
REQ-028 mem_ready arriving in the same cycle the counter reaches MEM_WAIT_MAX SHALL count as completion, not a timeout.
REQ-029 mem_ready outside FETCH, MEMRD and MEMWR SHALL be ignored.
REQ-030 TRAP SHALL drive all strobes to 0 and keep trap=1 until reset.

Reset
REQ-031 When reset=1 at a clock edge, the next state SHALL be FETCH, the wait counter 0, trap 0 and instret 0. This applies mid-access as well; any outstanding memory response is discarded.
REQ-032 While in reset, all outputs SHALL be the FETCH-state values except mem_req, which SHALL be 0 while reset is high.

Configuration
REQ-033 With MC_PERF_CNT_EN defined, instret SHALL increment by 1 (wrapping 0xFFFFFFFF -> 0) on every transition into FETCH from a completing state.
REQ-034 With MC_PERF_CNT_EN undefined, the instret port and its counter SHALL not exist.

Structure
REQ-035 The state enum, op_code constants, and the imm_src, alu_op and result_src encodings SHALL live in riscv_pkg.
REQ-036 The wait counter SHALL be a sub-module named mc_wait_timer.

Verification
REQ-037 lw: op_code 0000011, mem_ready delayed 2 cycles in FETCH and 0 in MEMRD -> state sequence FETCH x3, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 only in MEMWB.
REQ-038 beq with take=0 then take=1 -> pc_write in BRANCH is 0, then 1; each instruction takes 3 cycles with 0-wait memory.
REQ-039 op_code 1111111 -> TRAP after DECODE; trap=1 held for 20 cycles; reset pulse -> FETCH with trap=0.
REQ-040 With MEM_WAIT_MAX=4, mem_ready held low in MEMWR -> TRAP after 4 wait cycles; a repeat run with mem_ready on the 4th cycle -> FETCH.
REQ-041 reset asserted in MEMRD -> FETCH on the next edge; a late mem_ready produces no reg_write.
REQ-042 MC_PERF_CNT_EN defined, 10 back-to-back addi instructions -> instret=10.
